branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  Producer side of the fetch-unit branch interface: decodes the current instruction, evaluates
//  registered ALU condition flags and drives branch_en/bSIGN/bOFFSET into the PC unit.
//  Holds a 16-entry signed branch-offset table, a run/halt state machine and
//  saturating cycle/taken-branch counters. Sits between decode and fetch in the single-cycle core.
// PARAMETERS
//  PC_W      10   width of program counter input
//  OFF_W     8    branch offset magnitude width (matches bOFFSET)
//  LUT_AW    4    offset-table address width (16 entries)
//  HALT_PC   63   PC value that forces halt
//  CNT_W     16   width of statistics counters
// PORTS
//  CLK         in   1       clock, all state on rising edge
//  init_n      in   1       asynchronous active-low reset
//  start       in   1       pulse: begin (or restart) program execution
//  instr       in   9       current instruction; op=instr[8:5], lut index=instr[3:0]
//  PC          in   PC_W    current program counter from fetch unit
//  alu_zero    in   1       ALU zero result this cycle
//  alu_neg     in   1       ALU negative result this cycle
//  flag_we     in   1       latch alu_zero/alu_neg into flag register
//  lut_we      in   1       write offset table (legal in any state)
//  lut_addr    in   LUT_AW  offset table write address
//  lut_wdata   in   OFF_W+1 {sign, magnitude}
//  branch_en   out  1       take branch at next CLK edge
//  bSIGN       out  1       1 = PC - bOFFSET, 0 = PC + bOFFSET
//  bOFFSET     out  OFF_W   offset magnitude
//  halt        out  1       program finished (registered)
//  busy        out  1       state==RUN (registered)
//  cycle_cnt   out  CNT_W   RUN cycles since last start, saturating
//  branch_cnt  out  CNT_W   taken branches since last start, saturating
// BEHAVIOUR
//  Reset (async, init_n=0): state=IDLE; flags Z=N=0; all LUT entries 0; counters 0;
//   branch_en=bSIGN=0, bOFFSET=0, halt=0, busy=0. Reset mid-run aborts immediately.
//  States: IDLE -start-> RUN; RUN -HALT op or PC==HALT_PC-> HALTED; HALTED -start-> RUN.
//   start in RUN ignored. start on entering RUN clears both counters the same edge.
//  Opcodes: BEQ 4'b1100 taken if Z; BLT 4'b1101 taken if N; JMP 4'b1110 always; HALT 4'b1111.
//   All other opcodes: not taken.
//  branch_en/bSIGN/bOFFSET are combinational from instr, registered flags, LUT and state;
//   zero latency so the fetch unit samples them at the same edge. Outside RUN all three are 0.
//   When not taken, bSIGN=bOFFSET=0.
//  Flags: registered on flag_we; branch uses flags BEFORE this cycle's write (no bypass).
//  LUT: read asynchronously at instr[3:0]; a write lands at edge, visible next cycle
//   (same-cycle write+read of one entry returns old value).
//  Halt: HALT opcode or PC==HALT_PC in RUN -> HALTED at next edge; halt=1, busy=0 from that
//   edge until start or reset. A branch op at PC==HALT_PC is suppressed (halt wins).
//  Counters: cycle_cnt +1 every RUN cycle incl. halting cycle; branch_cnt +1 per taken branch;
//   both saturate at all-ones, hold in IDLE/HALTED.
//  Zero-magnitude offset is legal: branch_en=1, PC holds (self-loop).
// STRUCTURE
//  Package branch_pkg: opcode_e (BEQ/BLT/JMP/HALT), state_e (IDLE/RUN/HALTED),
//   lut_entry_t struct {logic sign; logic [OFF_W-1:0] mag}, HALT_PC default constant.
//  Sub-module branch_lut: 16 x lut_entry_t register file, async read, sync write, async clear.
//  Top: flag reg, FSM, decode/compare logic, two saturating counters.
// TESTING
//  Reset then start; instr=JMP idx3, LUT[3]={1,8'd5} -> branch_en=1,bSIGN=1,bOFFSET=5, branch_cnt=1.
//  flag_we with alu_zero=1, next cycle BEQ idx0 LUT[0]={0,8'd12} -> taken +12; same-cycle write -> not taken.
//  BLT with N=0 -> branch_en=0, bSIGN=0, bOFFSET=0; branch_cnt unchanged.
//  PC=63 with JMP in RUN -> branch_en=0, halt=1/busy=0 next edge; start -> RUN, counters=0.
//  Run 65540 non-branch cycles -> cycle_cnt holds 16'hFFFF.
//  Drop init_n mid-run async (between edges) -> all outputs 0 immediately, LUT reads 0, state IDLE.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch controller.
//   opcode_e    : branch-class opcodes decoded from instr[8:5]
//   state_e     : run/halt state machine encoding
//   lut_entry_t : one signed offset-table entry {sign, magnitude}
package branch_pkg;

  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned OFF_W_DEF   = 8;
  localparam int unsigned LUT_AW_DEF  = 4;
  localparam int unsigned HALT_PC_DEF = 63;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [3:0] {
    OP_BEQ  = 4'b1100,
    OP_BLT  = 4'b1101,
    OP_JMP  = 4'b1110,
    OP_HALT = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic                 sign;
    logic [OFF_W_DEF-1:0] mag;
  } lut_entry_t;

endpackage

// File: rtl/branch_lut.sv
// Branch-offset table: 2**LUT_AW entries of lut_entry_t.
//   clk, rst_n : clock, asynchronous active-low clear of every entry
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : asynchronous read port (a same-cycle write is not bypassed)
module branch_lut
  import branch_pkg::*;
#(
  parameter int unsigned LUT_AW = LUT_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  lut_entry_t        wdata,
  input  logic [LUT_AW-1:0] raddr,
  output lut_entry_t        rdata
);

  localparam int unsigned DEPTH = 2 ** LUT_AW;

  lut_entry_t mem_q [DEPTH];
  lut_entry_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Producer side of the fetch-unit branch interface.
// Decodes instr, evaluates registered ALU flags and drives a zero-latency
// branch request (branch_en/bSIGN/bOFFSET) into the PC unit.
//   CLK, init_n          : clock, asynchronous active-low reset
//   start                : begin/restart execution (ignored while running)
//   instr, PC            : current instruction and program counter
//   alu_zero/alu_neg, flag_we : flag register update
//   lut_we/lut_addr/lut_wdata : offset-table write port
//   branch_en/bSIGN/bOFFSET   : combinational branch request
//   halt, busy           : registered status
//   cycle_cnt/branch_cnt : saturating statistics since last start
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned OFF_W   = OFF_W_DEF,
  parameter int unsigned LUT_AW  = LUT_AW_DEF,
  parameter int unsigned HALT_PC = HALT_PC_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              init_n,
  input  logic              start,
  input  logic [8:0]        instr,
  input  logic [PC_W-1:0]   PC,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              flag_we,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_addr,
  input  logic [OFF_W:0]    lut_wdata,
  output logic              branch_en,
  output logic              bSIGN,
  output logic [OFF_W-1:0]  bOFFSET,
  output logic              halt,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  branch_cnt
);

  localparam logic [PC_W-1:0] HALT_PC_V = PC_W'(HALT_PC);

  state_e            state_q, state_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;

  logic [3:0]        op;
  logic [LUT_AW-1:0] lut_idx;
  lut_entry_t        lut_rd;
  logic              cond;
  logic              run;
  logic              at_halt_pc;
  logic              halt_req;
  logic              taken;
  logic              clr_cnt;
  logic              unused_instr;

  assign op           = instr[8:5];
  assign lut_idx      = instr[LUT_AW-1:0];
  assign unused_instr = instr[4];

  branch_lut #(
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk   (CLK),
    .rst_n (init_n),
    .we    (lut_we),
    .waddr (lut_addr),
    .wdata (lut_entry_t'(lut_wdata)),
    .raddr (lut_idx),
    .rdata (lut_rd)
  );

  // Decode and branch request. Flags are the registered values, so a
  // flag_we in the same cycle does not influence this cycle's decision.
  always_comb begin
    cond = 1'b0;
    case (op)
      OP_BEQ:  cond = flag_z_q;
      OP_BLT:  cond = flag_n_q;
      OP_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase

    run        = (state_q == ST_RUN);
    at_halt_pc = (PC == HALT_PC_V);
    halt_req   = (op == OP_HALT) || at_halt_pc;
    // Halt takes priority over any branch at the halt address.
    taken      = run && !at_halt_pc && cond;

    branch_en  = taken;
    bSIGN      = taken ? lut_rd.sign : 1'b0;
    bOFFSET    = taken ? lut_rd.mag  : '0;
  end

  // Run/halt state machine.
  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_RUN;
          clr_cnt = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag register and saturating statistics counters.
  always_comb begin
    flag_z_d     = flag_we ? alu_zero : flag_z_q;
    flag_n_d     = flag_we ? alu_neg  : flag_n_q;
    cycle_cnt_d  = cycle_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (clr_cnt) begin
      cycle_cnt_d  = '0;
      branch_cnt_d = '0;
    end else if (run) begin
      if (cycle_cnt_q != '1) begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
      if (taken && (branch_cnt_q != '1)) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state_q      <= ST_IDLE;
      flag_z_q     <= 1'b0;
      flag_n_q     <= 1'b0;
      cycle_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      flag_z_q     <= flag_z_d;
      flag_n_q     <= flag_n_d;
      cycle_cnt_q  <= cycle_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign halt       = (state_q == ST_HALTED);
  assign busy       = (state_q == ST_RUN);
  assign cycle_cnt  = cycle_cnt_q;
  assign branch_cnt = branch_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  logic        CLK;
  logic        init_n;
  logic        start;
  logic [8:0]  instr;
  logic [9:0]  PC;
  logic        alu_zero;
  logic        alu_neg;
  logic        flag_we;
  logic        lut_we;
  logic [3:0]  lut_addr;
  logic [8:0]  lut_wdata;
  logic        branch_en;
  logic        bSIGN;
  logic [7:0]  bOFFSET;
  logic        halt;
  logic        busy;
  logic [15:0] cycle_cnt;
  logic [15:0] branch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  branch_ctrl #(
    .PC_W    (10),
    .OFF_W   (8),
    .LUT_AW  (4),
    .HALT_PC (63),
    .CNT_W   (16)
  ) dut (
    .CLK        (CLK),
    .init_n     (init_n),
    .start      (start),
    .instr      (instr),
    .PC         (PC),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .flag_we    (flag_we),
    .lut_we     (lut_we),
    .lut_addr   (lut_addr),
    .lut_wdata  (lut_wdata),
    .branch_en  (branch_en),
    .bSIGN      (bSIGN),
    .bOFFSET    (bOFFSET),
    .halt       (halt),
    .busy       (busy),
    .cycle_cnt  (cycle_cnt),
    .branch_cnt (branch_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [8:0] ins(input logic [3:0] op, input logic [3:0] idx);
    return {op, 1'b0, idx};
  endfunction

  task automatic chk_br(input string tag, input logic en, input logic sg, input logic [7:0] off);
    #2;
    check({tag, ".en"},  32'(branch_en), 32'(en));
    check({tag, ".sgn"}, 32'(bSIGN),     32'(sg));
    check({tag, ".off"}, 32'(bOFFSET),   32'(off));
  endtask

  initial begin
    init_n = 1'b0; start = 1'b0; instr = '0; PC = 10'd10;
    alu_zero = 1'b0; alu_neg = 1'b0; flag_we = 1'b0;
    lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;

    #7;
    check("rst.en",     32'(branch_en),  0);
    check("rst.off",    32'(bOFFSET),    0);
    check("rst.halt",   32'(halt),       0);
    check("rst.busy",   32'(busy),       0);
    check("rst.cycle",  32'(cycle_cnt),  0);
    check("rst.branch", 32'(branch_cnt), 0);

    @(posedge CLK); #1;
    init_n = 1'b1;

    // Table writes while idle
    lut_we = 1'b1; lut_addr = 4'd3; lut_wdata = {1'b1, 8'd5};
    cyc();
    lut_addr = 4'd0; lut_wdata = {1'b0, 8'd12};
    cyc();
    lut_we = 1'b0;

    instr = ins(4'b1110, 4'd3);
    chk_br("idle_jmp", 1'b0, 1'b0, 8'd0);
    check("idle.busy", 32'(busy), 0);

    start = 1'b1; instr = '0;
    cyc();
    start = 1'b0;
    check("start.busy",   32'(busy),       1);
    check("start.halt",   32'(halt),       0);
    check("start.cycle",  32'(cycle_cnt),  0);
    check("start.branch", 32'(branch_cnt), 0);

    // JMP idx3 -> PC - 5
    instr = ins(4'b1110, 4'd3);
    chk_br("jmp3", 1'b1, 1'b1, 8'd5);
    cyc();
    check("jmp3.cycle",  32'(cycle_cnt),  1);
    check("jmp3.branch", 32'(branch_cnt), 1);

    // Set Z then BEQ idx0 -> +12
    instr = '0; flag_we = 1'b1; alu_zero = 1'b1;
    cyc();
    flag_we = 1'b0;
    instr = ins(4'b1100, 4'd0);
    chk_br("beq_z1", 1'b1, 1'b0, 8'd12);
    cyc();
    check("beq_z1.branch", 32'(branch_cnt), 2);

    // Clear Z, then BEQ in the same cycle Z is written -> old Z=0 used
    instr = '0; flag_we = 1'b1; alu_zero = 1'b0;
    cyc();
    alu_zero = 1'b1; instr = ins(4'b1100, 4'd0);
    chk_br("beq_samecyc", 1'b0, 1'b0, 8'd0);
    cyc();
    flag_we = 1'b0;
    check("beq_samecyc.cycle",  32'(cycle_cnt),  5);
    check("beq_samecyc.branch", 32'(branch_cnt), 2);

    // Same-cycle table write returns old entry, new one next cycle
    lut_we = 1'b1; lut_addr = 4'd0; lut_wdata = {1'b1, 8'd7};
    chk_br("lut_old", 1'b1, 1'b0, 8'd12);
    cyc();
    lut_we = 1'b0;
    chk_br("lut_new", 1'b1, 1'b1, 8'd7);
    cyc();
    check("lut_new.branch", 32'(branch_cnt), 4);

    // BLT with N=0 -> not taken
    instr = ins(4'b1101, 4'd3);
    chk_br("blt_n0", 1'b0, 1'b0, 8'd0);
    cyc();
    check("blt_n0.branch", 32'(branch_cnt), 4);

    // Zero-magnitude offset still branches
    instr = ins(4'b1110, 4'd5);
    chk_br("jmp_zero", 1'b1, 1'b0, 8'd0);
    cyc();
    check("jmp_zero.branch", 32'(branch_cnt), 5);

    // Set N then BLT idx3
    instr = '0; flag_we = 1'b1; alu_neg = 1'b1; alu_zero = 1'b0;
    cyc();
    flag_we = 1'b0;
    instr = ins(4'b1101, 4'd3);
    chk_br("blt_n1", 1'b1, 1'b1, 8'd5);
    cyc();
    check("blt_n1.cycle",  32'(cycle_cnt),  11);
    check("blt_n1.branch", 32'(branch_cnt), 6);

    // Non-branch opcode
    instr = ins(4'b0111, 4'd3);
    chk_br("other_op", 1'b0, 1'b0, 8'd0);
    cyc();

    // JMP at the halt address is suppressed and halts
    PC = 10'd63; instr = ins(4'b1110, 4'd3);
    chk_br("jmp_at_halt", 1'b0, 1'b0, 8'd0);
    check("pre_halt.busy", 32'(busy), 1);
    cyc();
    check("haltpc.halt",   32'(halt),       1);
    check("haltpc.busy",   32'(busy),       0);
    check("haltpc.cycle",  32'(cycle_cnt),  13);
    check("haltpc.branch", 32'(branch_cnt), 6);
    PC = 10'd10;
    chk_br("halted_jmp", 1'b0, 1'b0, 8'd0);
    cyc();
    check("halted.cycle_hold", 32'(cycle_cnt), 13);

    // Restart clears counters
    start = 1'b1; instr = '0;
    cyc();
    start = 1'b0;
    check("restart.busy",   32'(busy),       1);
    check("restart.halt",   32'(halt),       0);
    check("restart.cycle",  32'(cycle_cnt),  0);
    check("restart.branch", 32'(branch_cnt), 0);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_in_run.cycle", 32'(cycle_cnt), 2);
    check("start_in_run.busy",  32'(busy),      1);

    // HALT opcode
    instr = ins(4'b1111, 4'd3);
    chk_br("halt_op", 1'b0, 1'b0, 8'd0);
    cyc();
    check("halt_op.halt",  32'(halt),      1);
    check("halt_op.busy",  32'(busy),      0);
    check("halt_op.cycle", 32'(cycle_cnt), 3);

    start = 1'b1; instr = '0;
    cyc();
    start = 1'b0;
    check("restart2.cycle", 32'(cycle_cnt), 0);

    // Saturation
    repeat (65540) cyc();
    check("sat.cycle",  32'(cycle_cnt),  32'hFFFF);
    check("sat.branch", 32'(branch_cnt), 0);
    check("sat.busy",   32'(busy),       1);

    // Asynchronous reset between edges
    instr = ins(4'b1110, 4'd3);
    chk_br("pre_rst", 1'b1, 1'b1, 8'd5);
    #3;
    init_n = 1'b0;
    #1;
    check("arst.en",     32'(branch_en),  0);
    check("arst.sgn",    32'(bSIGN),      0);
    check("arst.off",    32'(bOFFSET),    0);
    check("arst.halt",   32'(halt),       0);
    check("arst.busy",   32'(busy),       0);
    check("arst.cycle",  32'(cycle_cnt),  0);
    check("arst.branch", 32'(branch_cnt), 0);
    cyc();
    init_n = 1'b1;
    chk_br("arst_idle", 1'b0, 1'b0, 8'd0);
    check("arst_idle.busy", 32'(busy), 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_br("arst_lut0", 1'b1, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
